// File: rtl/button_pkg.sv
// button_pkg: shared counter widths, repeat FSM encoding and default timing for the button conditioner
package button_pkg;
  localparam int DB_W = 8;
  localparam int RPT_W = 12;
  localparam int DEF_CLK_HZ = 100_000_000;
  localparam int DEF_DEBOUNCE_MS = 10;
  localparam int DEF_REPEAT_DELAY_MS = 500;
  localparam int DEF_REPEAT_RATE_MS = 100;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RPT   = 2'd2
  } rpt_state_t;
endpackage

// File: rtl/button_channel.sv
// button_channel: synchroniser, debounce, edge pulses and optional auto-repeat for one button
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS,
  parameter int REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS,
  parameter int REPEAT_RATE_MS = DEF_REPEAT_RATE_MS,
  parameter bit REPEAT_EN = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_raw,
  input  logic tick,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);
  logic r_meta, r_sync, r_level, r_press, r_release;
  logic [DB_W-1:0] r_db_cnt;
  logic w_accept, w_rise, w_fall;
  assign w_accept = (r_sync != r_level) && tick && (r_db_cnt == DB_W'(DEBOUNCE_MS - 1));
  assign w_rise = w_accept && r_sync;
  assign w_fall = w_accept && !r_sync;
  assign btn_level = r_level;
  assign btn_press = r_press;
  assign btn_release = r_release;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_release <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_meta <= btn_raw;
      r_sync <= r_meta;
      r_press <= w_rise;
      r_release <= w_fall;
      if (r_sync == r_level) r_db_cnt <= '0;
      else if (w_accept) begin
        r_level <= r_sync;
        r_db_cnt <= '0;
      end else if (tick) r_db_cnt <= r_db_cnt + 1'b1;
    end
  end
  if (REPEAT_EN) begin : g_rpt
    rpt_state_t r_state;
    logic [RPT_W-1:0] r_rpt_cnt;
    logic r_repeat;
    logic [RPT_W-1:0] w_lim;
    assign w_lim = (r_state == DELAY) ? RPT_W'(REPEAT_DELAY_MS - 1) : RPT_W'(REPEAT_RATE_MS - 1);
    assign btn_repeat = r_repeat;
    // A release accepted on the same edge as a repeat tick suppresses that repeat
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_state <= IDLE;
        r_rpt_cnt <= '0;
        r_repeat <= 1'b0;
      end else begin
        r_repeat <= 1'b0;
        if (w_fall || (r_state != IDLE && !r_level)) begin
          r_state <= IDLE;
          r_rpt_cnt <= '0;
        end else begin
          case (r_state)
            IDLE: if (w_rise) begin
              r_repeat <= 1'b1;
              r_rpt_cnt <= '0;
              r_state <= DELAY;
            end
            DELAY, RPT: if (tick) begin
              if (r_rpt_cnt == w_lim) begin
                r_repeat <= 1'b1;
                r_rpt_cnt <= '0;
                r_state <= RPT;
              end else r_rpt_cnt <= r_rpt_cnt + 1'b1;
            end
            default: r_state <= IDLE;
          endcase
        end
      end
    end
  end else begin : g_no_rpt
    assign btn_repeat = 1'b0;
  end
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: shared 1 ms prescaler plus one conditioning channel per pushbutton
module button_conditioner
  import button_pkg::*;
#(
  parameter int CLK_HZ = DEF_CLK_HZ,
  parameter int N_BTN = 3,
  parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS,
  parameter int REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS,
  parameter int REPEAT_RATE_MS = DEF_REPEAT_RATE_MS,
  parameter logic [N_BTN-1:0] REPEAT_MASK = 3'b010
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             tick_1ms
);
  localparam int TICK_CYC = CLK_HZ / 1000;
  localparam int PRE_W = $clog2(TICK_CYC);
  logic [PRE_W-1:0] r_pre;
  logic r_tick;
  assign tick_1ms = r_tick;
  // Tick is registered one count early so it is high exactly while r_pre == TICK_CYC-1
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pre <= '0;
      r_tick <= 1'b0;
    end else begin
      r_pre <= (r_pre == PRE_W'(TICK_CYC - 1)) ? '0 : r_pre + 1'b1;
      r_tick <= (r_pre == PRE_W'(TICK_CYC - 2));
    end
  end
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_MS(DEBOUNCE_MS),
      .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
      .REPEAT_RATE_MS(REPEAT_RATE_MS),
      .REPEAT_EN(REPEAT_MASK[i])
    ) u_ch (
      .clock(clock),
      .reset_n(reset_n),
      .btn_raw(btn_raw[i]),
      .tick(r_tick),
      .btn_level(btn_level[i]),
      .btn_press(btn_press[i]),
      .btn_release(btn_release[i]),
      .btn_repeat(btn_repeat[i])
    );
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed self-checking bench for button_conditioner
module tb_button_conditioner;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [2:0] btn_raw = '0;
  logic [2:0] lvl, prs, rel, rpt;
  logic tick;
  int checks = 0, failures = 0, cyc = 0;
  int press_n[3], rel_n[3], rpt_n[3], press_t[3], rel_t[3];
  int rpt_q[$];
  int last_tick = -1, tick_gap = 0, tick_n = 0;
  int rst_bad, start, lat, tp;
  int expo[9] = '{0, 50, 70, 90, 110, 130, 150, 170, 190};

  always #5 clk = ~clk;

  button_conditioner #(
    .CLK_HZ(10_000),
    .N_BTN(3),
    .DEBOUNCE_MS(3),
    .REPEAT_DELAY_MS(5),
    .REPEAT_RATE_MS(2),
    .REPEAT_MASK(3'b010)
  ) dut (
    .clock(clk),
    .reset_n(reset_n),
    .btn_raw(btn_raw),
    .btn_level(lvl),
    .btn_press(prs),
    .btn_release(rel),
    .btn_repeat(rpt),
    .tick_1ms(tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (prs[i]) begin press_n[i]++; press_t[i] = cyc; end
      if (rel[i]) begin rel_n[i]++; rel_t[i] = cyc; end
      if (rpt[i]) begin
        rpt_n[i]++;
        if (i == 1) rpt_q.push_back(cyc);
      end
    end
    if (tick) begin
      if (last_tick >= 0) tick_gap = cyc - last_tick;
      last_tick = cyc;
      tick_n++;
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 3; i++) begin
      press_n[i] = 0; rel_n[i] = 0; rpt_n[i] = 0; press_t[i] = 0; rel_t[i] = 0;
    end
    rpt_q.delete();
    tick_n = 0;
    last_tick = -1;
    tick_gap = 0;
  endtask

  initial begin
    clr();
    rst_bad = 0;
    for (int k = 0; k < 12; k++) begin
      btn_raw = 3'(k);
      step();
      if ({lvl, prs, rel, rpt, tick} !== 13'd0) rst_bad++;
    end
    chk("reset_outputs", rst_bad, 0);
    btn_raw = '0;
    repeat (3) step();
    reset_n = 1'b1;
    clr();
    repeat (8) step();
    chk("tick_before_first", tick, 0);
    step();
    chk("tick_first", tick, 1);
    step();
    chk("tick_width", tick, 0);
    repeat (30) step();
    chk("tick_period", tick_gap, 10);
    chk("tick_count", tick_n, 4);

    clr();
    start = cyc;
    btn_raw[0] = 1'b1;
    for (int k = 0; k < 40 && press_n[0] == 0; k++) step();
    lat = press_t[0] - start;
    chk("press0_latency_in_window", (lat >= 22 && lat <= 32), 1);
    repeat (40) step();
    chk("press0_count", press_n[0], 1);
    chk("level0_high", lvl[0], 1);
    chk("repeat0_masked", rpt_n[0], 0);
    clr();
    start = cyc;
    btn_raw[0] = 1'b0;
    for (int k = 0; k < 40 && rel_n[0] == 0; k++) step();
    lat = rel_t[0] - start;
    chk("release0_latency_in_window", (lat >= 22 && lat <= 32), 1);
    repeat (40) step();
    chk("release0_count", rel_n[0], 1);
    chk("level0_low", lvl[0], 0);
    chk("release0_no_press", press_n[0], 0);

    clr();
    for (int k = 0; k < 14; k++) begin
      btn_raw[0] = ~btn_raw[0];
      repeat (7) step();
    end
    chk("bounce_no_pulses", press_n[0] + rel_n[0], 0);
    chk("bounce_level_low", lvl[0], 0);
    btn_raw[0] = 1'b1;
    repeat (45) step();
    chk("bounce_settled_press", press_n[0], 1);
    chk("bounce_settled_level", lvl[0], 1);
    btn_raw[0] = 1'b0;
    repeat (45) step();
    chk("bounce_release_level", lvl[0], 0);

    clr();
    btn_raw[2] = 1'b1;
    repeat (15) step();
    btn_raw[2] = 1'b0;
    repeat (40) step();
    chk("glitch_no_press", press_n[2], 0);
    chk("glitch_level_low", lvl[2], 0);

    clr();
    btn_raw = 3'b101;
    for (int k = 0; k < 40 && press_n[0] == 0; k++) step();
    repeat (5) step();
    chk("simul_press0", press_n[0], 1);
    chk("simul_press2", press_n[2], 1);
    chk("simul_same_cycle", press_t[0] - press_t[2], 0);
    btn_raw = 3'b000;
    repeat (45) step();
    chk("simul_levels_low", lvl, 0);

    clr();
    btn_raw[1] = 1'b1;
    for (int k = 0; k < 40 && press_n[1] == 0; k++) step();
    tp = press_t[1];
    repeat (185) step();
    btn_raw[1] = 1'b0;
    repeat (40) step();
    chk("rpt_press_count", press_n[1], 1);
    chk("rpt_release_offset", rel_t[1] - tp, 210);
    chk("rpt_pulse_count", rpt_q.size(), 9);
    for (int i = 0; i < 9; i++) chk($sformatf("rpt_offset_%0d", i), rpt_q[i] - tp, expo[i]);
    chk("rpt_bit0_zero", rpt_n[0], 0);
    chk("rpt_bit2_zero", rpt_n[2], 0);
    chk("rpt_level_low", lvl[1], 0);

    clr();
    btn_raw[1] = 1'b1;
    for (int k = 0; k < 40 && press_n[1] == 0; k++) step();
    tp = press_t[1];
    repeat (75) step();
    chk("hold_level_high", lvl[1], 1);
    chk("hold_rpt_count", rpt_n[1], 3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", {lvl, prs, rel, rpt, tick}, 0);
    repeat (3) step();
    reset_n = 1'b1;
    clr();
    start = cyc;
    for (int k = 0; k < 45 && press_n[1] == 0; k++) step();
    chk("requal_press_latency", press_t[1] - start, 30);
    tp = press_t[1];
    repeat (55) step();
    chk("requal_rpt_count", rpt_q.size(), 2);
    chk("requal_rpt_first", rpt_q[0] - tp, 0);
    chk("requal_rpt_delay", rpt_q[1] - tp, 50);
    btn_raw[1] = 1'b0;
    repeat (45) step();
    chk("final_level_low", lvl[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
